// File: rtl/io_input_conditioner.sv
// ---------------------------------------------------------------------------
// io_input_conditioner
//
// Front end between the board pins and the IO module.
//   - Every pin goes through a two-flop synchroniser. All logic after that
//     sees only the second stage (key: ks, switches: ss).
//   - The active-low confirm key is debounced by a four-state FSM. It emits a
//     single-cycle Confirm pulse for each accepted press.
//   - The switch bus is debounced as one word. A change on any bit restarts
//     the stability count for the whole bus.
//
// Build option:
//   CONFIRM_SNAPSHOT_EN  When defined, Raw_Input loads only on the edge that
//                        raises Confirm. It takes the debounced switch word,
//                        or keeps its old value if the bus is still settling.
//                        When undefined, Raw_Input tracks the debounced
//                        switches continuously.
//
// Parameters:
//   SW_WIDTH         switch bus width
//   DEBOUNCE_CYCLES  stable cycles needed before a change is accepted (>= 2)
//   CNT_WIDTH        counter width, must hold DEBOUNCE_CYCLES-1
//
// Ports:
//   Clock          in   system clock, rising edge
//   Reset          in   synchronous, active-high
//   Key_n          in   raw confirm button, asynchronous, 0 = pressed
//   Switch_Raw     in   raw slide switches, asynchronous
//   Confirm        out  one-cycle pulse per accepted press
//   Confirm_Level  out  debounced key level, 1 = pressed
//   Raw_Input      out  debounced switch word
//
// Key FSM states:
//   state        | meaning
//   IDLE         | key released and stable
//   PRESS_WAIT   | key seen low, counting stable-low cycles
//   PRESSED      | press accepted, Confirm already issued
//   RELEASE_WAIT | key seen high, counting stable-high cycles
// ---------------------------------------------------------------------------
module io_input_conditioner #(
  parameter int SW_WIDTH        = 18,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Key_n,
  input  logic [SW_WIDTH-1:0] Switch_Raw,
  output logic                Confirm,
  output logic                Confirm_Level,
  output logic [SW_WIDTH-1:0] Raw_Input
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  // Terminal count shared by the key and switch counters.
  localparam logic [CNT_WIDTH-1:0] CNT_TC  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // Synchronisers
  logic                key_meta_q, key_meta_d;
  logic                key_sync_q, key_sync_d;
  logic [SW_WIDTH-1:0] sw_meta_q,  sw_meta_d;
  logic [SW_WIDTH-1:0] sw_sync_q,  sw_sync_d;

  // Key path
  key_state_e          state_q,    state_d;
  logic [CNT_WIDTH-1:0] kc_q,      kc_d;
  logic                confirm_q,  confirm_d;
  logic                level_q,    level_d;

  // Switch path
  logic [SW_WIDTH-1:0] cand_q,     cand_d;
  logic [CNT_WIDTH-1:0] sc_q,      sc_d;
  logic [SW_WIDTH-1:0] raw_q,      raw_d;

  logic                ks;
  logic [SW_WIDTH-1:0] ss;
  logic                sw_stable;

  assign ks = key_sync_q;
  assign ss = sw_sync_q;

  // -------------------------------------------------------------------------
  // Synchroniser next-state
  // -------------------------------------------------------------------------
  always_comb begin
    key_meta_d = Key_n;
    key_sync_d = key_meta_q;
    sw_meta_d  = Switch_Raw;
    sw_sync_d  = sw_meta_q;
  end

  // -------------------------------------------------------------------------
  // Key FSM next-state and outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    kc_d      = kc_q;
    confirm_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!ks) begin
          state_d = PRESS_WAIT;
          kc_d    = '0;
        end
      end

      PRESS_WAIT: begin
        if (ks) begin
          // A bounce back high abandons this press attempt.
          state_d = IDLE;
          kc_d    = '0;
        end else if (kc_q == CNT_TC) begin
          state_d   = PRESSED;
          confirm_d = 1'b1;
        end else begin
          kc_d = kc_q + CNT_ONE;
        end
      end

      PRESSED: begin
        if (ks) begin
          state_d = RELEASE_WAIT;
          kc_d    = '0;
        end
      end

      RELEASE_WAIT: begin
        if (!ks) begin
          // A release bounce returns to PRESSED without a second pulse.
          state_d = PRESSED;
          kc_d    = '0;
        end else if (kc_q == CNT_TC) begin
          state_d = IDLE;
        end else begin
          kc_d = kc_q + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        kc_d    = '0;
      end
    endcase

    // The level output is registered from the next state, so it rises on
    // the same edge as Confirm.
    level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
  end

  // -------------------------------------------------------------------------
  // Switch debounce: the whole bus is treated as a single candidate word.
  // -------------------------------------------------------------------------
  always_comb begin
    cand_d    = cand_q;
    sc_d      = sc_q;
    sw_stable = 1'b0;

    if (ss != cand_q) begin
      cand_d = ss;
      sc_d   = '0;
    end else if (sc_q != CNT_TC) begin
      sc_d = sc_q + CNT_ONE;
    end else begin
      // The counter saturates at terminal count. The word stays accepted
      // until the next change on the bus.
      sw_stable = 1'b1;
    end
  end

`ifdef CONFIRM_SNAPSHOT_EN
  // Capture the debounced word only at the moment of confirmation. If the
  // bus is still settling at that point, the previous word is kept.
  always_comb begin
    raw_d = raw_q;
    if (confirm_d) begin
      raw_d = (sc_q == CNT_TC) ? cand_q : raw_q;
    end
  end
`else
  always_comb begin
    raw_d = raw_q;
    if (sw_stable) begin
      raw_d = cand_q;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (Reset) begin
      // The key synchroniser resets to "released". If the key is held low
      // across reset, the press is treated as new and fully debounced.
      key_meta_q <= 1'b1;
      key_sync_q <= 1'b1;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      state_q    <= IDLE;
      kc_q       <= '0;
      confirm_q  <= 1'b0;
      level_q    <= 1'b0;
      cand_q     <= '0;
      sc_q       <= '0;
      raw_q      <= '0;
    end else begin
      key_meta_q <= key_meta_d;
      key_sync_q <= key_sync_d;
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
      state_q    <= state_d;
      kc_q       <= kc_d;
      confirm_q  <= confirm_d;
      level_q    <= level_d;
      cand_q     <= cand_d;
      sc_q       <= sc_d;
      raw_q      <= raw_d;
    end
  end

  assign Confirm       = confirm_q;
  assign Confirm_Level = level_q;
  assign Raw_Input     = raw_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
module tb_io_input_conditioner;

  localparam int SW = 18;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          key_n;
  logic [SW-1:0] sw_raw;
  logic          confirm;
  logic          conf_lvl;
  logic [SW-1:0] raw_in;

  io_input_conditioner #(
    .SW_WIDTH        (SW),
    .DEBOUNCE_CYCLES (DB),
    .CNT_WIDTH       (3)
  ) dut (
    .Clock         (clk),
    .Reset         (rst),
    .Key_n         (key_n),
    .Switch_Raw    (sw_raw),
    .Confirm       (confirm),
    .Confirm_Level (conf_lvl),
    .Raw_Input     (raw_in)
  );

  always #5 clk = ~clk;

  // Number of rising edges so far; read on falling edges only.
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    int            cyc;
    logic [SW-1:0] val;
  } exp_t;

  int   q_conf[$];
  exp_t q_lvl[$];
  exp_t q_raw[$];

  bit            mon_en = 1'b0;
  logic          lvl_prev;
  logic [SW-1:0] raw_prev;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic void fail(string name, string what);
    n_total++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endfunction

  function automatic void push_lvl(int c, logic v);
    exp_t e;
    e.cyc = c;
    e.val = SW'(v);
    q_lvl.push_back(e);
  endfunction

  function automatic void push_raw(int c, logic [SW-1:0] v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    q_raw.push_back(e);
  endfunction

  // Monitor: every output event pops the expected entry from its queue.
  always @(negedge clk) begin
    exp_t e;
    if (!mon_en) begin
      lvl_prev = conf_lvl;
      raw_prev = raw_in;
    end else begin
      if (confirm === 1'b1) begin
        if (q_conf.size() == 0) fail("confirm_unexpected", "pulse seen, none expected");
        else check("confirm_cycle", 32'(cyc), 32'(q_conf.pop_front()));
      end else if (confirm !== 1'b0) begin
        fail("confirm_unknown", "Confirm is X/Z");
      end

      if (conf_lvl !== lvl_prev) begin
        if (q_lvl.size() == 0) begin
          fail("level_unexpected", $sformatf("level changed to %b", conf_lvl));
        end else begin
          e = q_lvl.pop_front();
          check("level_cycle", 32'(cyc), 32'(e.cyc));
          check("level_value", 32'(conf_lvl), 32'(e.val));
        end
        lvl_prev = conf_lvl;
      end

      if (raw_in !== raw_prev) begin
        if (q_raw.size() == 0) begin
          fail("raw_unexpected", $sformatf("Raw_Input changed to %h", raw_in));
        end else begin
          e = q_raw.pop_front();
          check("raw_cycle", 32'(cyc), 32'(e.cyc));
          check("raw_value", 32'(raw_in), 32'(e.val));
        end
        raw_prev = raw_in;
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int c;
    logic [SW-1:0] raw_after_glitch;

    rst    = 1'b1;
    key_n  = 1'b1;
    sw_raw = '0;

    // Hold reset for 3 cycles while all the pins toggle.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_confirm", 32'(confirm), 32'(0));
      check("rst_level",   32'(conf_lvl), 32'(0));
      check("rst_raw",     32'(raw_in),  32'(0));
      key_n  = ~key_n;
      sw_raw = ~sw_raw;
    end
    rst    = 1'b0;
    key_n  = 1'b1;
    sw_raw = '0;
    mon_en = 1'b1;
    tick(10);

    // Clean press of 20 cycles.
    c = cyc;
    key_n = 1'b0;
    q_conf.push_back(c + 7);
    push_lvl(c + 7, 1'b1);
    tick(20);
    c = cyc;
    key_n = 1'b1;
    push_lvl(c + 7, 1'b0);
    tick(15);

    // Bouncy press: low 2, high 1, then low 20.
    c = cyc;
    key_n = 1'b0;
    tick(2);
    key_n = 1'b1;
    tick(1);
    key_n = 1'b0;
    q_conf.push_back(c + 10);
    push_lvl(c + 10, 1'b1);
    tick(20);
    c = cyc;
    key_n = 1'b1;
    push_lvl(c + 7, 1'b0);
    tick(15);

    // Short press of 3 cycles: it is rejected.
    key_n = 1'b0;
    tick(3);
    key_n = 1'b1;
    tick(12);
    check("short_press_level", 32'(conf_lvl), 32'(0));

    // Stable switch word, then a 2-cycle glitch on bit 0.
    c = cyc;
    sw_raw = 18'h2A5A5;
`ifndef CONFIRM_SNAPSHOT_EN
    push_raw(c + 7, 18'h2A5A5);
    raw_after_glitch = 18'h2A5A5;
`else
    raw_after_glitch = '0;
`endif
    tick(12);
    sw_raw = 18'h2A5A4;
    tick(2);
    sw_raw = 18'h2A5A5;
    tick(12);
    check("glitch_hold", 32'(raw_in), 32'(raw_after_glitch));

    // Press with the switches stable.
    c = cyc;
    key_n = 1'b0;
    q_conf.push_back(c + 7);
    push_lvl(c + 7, 1'b1);
`ifdef CONFIRM_SNAPSHOT_EN
    push_raw(c + 7, 18'h2A5A5);
`endif
    tick(10);
    c = cyc;
    key_n = 1'b1;
    push_lvl(c + 7, 1'b0);
    tick(12);
    check("pressed_raw", 32'(raw_in), 32'(18'h2A5A5));

    // Reset asserted during PRESS_WAIT (kc=2), with the key kept low.
    c = cyc;
    key_n = 1'b0;
    tick(5);
    rst = 1'b1;
    push_raw(c + 6, '0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("midrst_confirm", 32'(confirm),  32'(0));
      check("midrst_level",   32'(conf_lvl), 32'(0));
      check("midrst_raw",     32'(raw_in),   32'(0));
    end
    rst = 1'b0;
    q_conf.push_back(c + 15);
    push_lvl(c + 15, 1'b1);
    push_raw(c + 15, 18'h2A5A5);
    tick(12);
    c = cyc;
    key_n = 1'b1;
    push_lvl(c + 7, 1'b0);
    tick(15);

    // Any expected event that never arrived is a failure.
    while (q_conf.size() > 0) begin
      fail("confirm_missing", $sformatf("expected pulse at cycle %0d", q_conf.pop_front()));
    end
    while (q_lvl.size() > 0) begin
      exp_t e;
      e = q_lvl.pop_front();
      fail("level_missing", $sformatf("expected level %0h at cycle %0d", e.val, e.cyc));
    end
    while (q_raw.size() > 0) begin
      exp_t e;
      e = q_raw.pop_front();
      fail("raw_missing", $sformatf("expected raw %h at cycle %0d", e.val, e.cyc));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
